// File: rtl/mm_pkg.sv
// Shared constants and state encoding for the matrix-multiplier result display.
package mm_pkg;
   localparam int ELEM_W = 4;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_SHOW = 2'd1;
   localparam state_t ST_ERR  = 2'd2;

   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [6:0] SEG_ERR   = 7'h79;
endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to seven-segment {g,f,e,d,c,b,a}, active-high.
module seg7_hex_decode (
   input  logic [3:0] hex,
   output logic [6:0] seg
);
   always_comb begin
      seg = 7'h00;
      case (hex)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         4'hF: seg = 7'h71;
         default: seg = 7'h00;
      endcase
   end
endmodule

// File: rtl/mm_result_display.sv
// Cycles the four 2x2 product elements onto a seven-segment digit, one per dwell
// period, or shows 'E' when the multiplier flagged an operand range error.
module mm_result_display
   import mm_pkg::*;
#(
   parameter int DWELL_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [15:0] res_in,
   input  logic        res_valid,
   input  logic        err_in,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [1:0]  idx,
   output logic        busy
);
   localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DWELL_CYCLES - 1);

   state_t       state, state_nxt;
   logic [15:0]  hold, hold_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [1:0]   idx_nxt;
   logic [ELEM_W-1:0] elem;
   logic [6:0]   dec_seg, seg_nxt;

   always_comb begin
      state_nxt = state;
      hold_nxt  = hold;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      if (res_valid) begin
         // A new result (or error) always preempts whatever is on display.
         state_nxt = err_in ? ST_ERR : ST_SHOW;
         if (!err_in) hold_nxt = res_in;
         idx_nxt   = 2'd0;
         cnt_nxt   = '0;
      end else if (state == ST_SHOW) begin
         if (cnt == CNT_MAX) begin
            cnt_nxt = '0;
            idx_nxt = idx + 2'd1;
         end else begin
            cnt_nxt = cnt + 1'b1;
         end
      end
   end

   // Decode the element that will be visible after this edge so seg is registered
   // yet tracks the capture edge with no extra latency.
   always_comb begin
      elem = hold_nxt[3:0];
      case (idx_nxt)
         2'd1:    elem = hold_nxt[7:4];
         2'd2:    elem = hold_nxt[11:8];
         2'd3:    elem = hold_nxt[15:12];
         default: elem = hold_nxt[3:0];
      endcase
   end

   seg7_hex_decode u_dec (
      .hex (elem),
      .seg (dec_seg)
   );

   always_comb begin
      seg_nxt = SEG_BLANK;
      case (state_nxt)
         ST_SHOW: seg_nxt = dec_seg;
         ST_ERR:  seg_nxt = SEG_ERR;
         default: seg_nxt = SEG_BLANK;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         hold  <= 16'h0000;
         cnt   <= '0;
         idx   <= 2'd0;
         seg   <= SEG_BLANK;
         dp    <= 1'b0;
         busy  <= 1'b0;
      end else if (ena) begin
         state <= state_nxt;
         hold  <= hold_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         seg   <= seg_nxt;
         dp    <= (state_nxt == ST_SHOW) && (idx_nxt == 2'd0);
         busy  <= (state_nxt != ST_IDLE);
      end
   end
endmodule

// File: tb/tb_mm_result_display.sv
// Directed bench: expected {seg,dp,idx,busy} pushed per cycle, popped after each edge.
module tb_mm_result_display;
   logic        clk = 1'b0;
   logic        rst_n, ena, res_valid, err_in;
   logic [15:0] res_in;
   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b, busy_a, busy_b;
   logic [1:0]  idx_a, idx_b;

   int errors = 0;
   int checks = 0;
   logic [10:0] q_a[$];
   logic [10:0] q_b[$];

   always #5 clk = ~clk;

   mm_result_display #(.DWELL_CYCLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .res_in(res_in), .res_valid(res_valid),
      .err_in(err_in), .seg(seg_a), .dp(dp_a), .idx(idx_a), .busy(busy_a));

   mm_result_display #(.DWELL_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .res_in(res_in), .res_valid(res_valid),
      .err_in(err_in), .seg(seg_b), .dp(dp_b), .idx(idx_b), .busy(busy_b));

   function automatic logic [10:0] ex(input logic [6:0] s, input logic d,
                                      input logic [1:0] i, input logic b);
      return {s, d, i, b};
   endfunction

   task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: got seg/dp/idx/busy=%h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic push_a(input int n, input logic [6:0] s, input logic d,
                         input logic [1:0] i, input logic b);
      for (int k = 0; k < n; k++) q_a.push_back(ex(s, d, i, b));
   endtask

   // One clock: sample #1 after the edge and compare against queued expectations.
   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      if (q_a.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty for dwell-4 instance", tag);
      end else begin
         check({tag, "_d4"}, {seg_a, dp_a, idx_a, busy_a}, q_a.pop_front());
      end
      if (q_b.size() != 0)
         check({tag, "_d1"}, {seg_b, dp_b, idx_b, busy_b}, q_b.pop_front());
   endtask

   task automatic run(input int n, input string tag);
      for (int k = 0; k < n; k++) tick(tag);
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b0; res_valid = 1'b0; err_in = 1'b0; res_in = 16'h0;
      #3;
      check("reset_d4", {seg_a, dp_a, idx_a, busy_a}, ex(7'h00, 0, 0, 0));
      check("reset_d1", {seg_b, dp_b, idx_b, busy_b}, ex(7'h00, 0, 0, 0));
      #20 rst_n = 1'b1;
      @(posedge clk); #1;

      // Idle with enable high stays blank.
      ena = 1'b1;
      push_a(3, 7'h00, 0, 0, 0);
      run(3, "idle");

      // Full sequence of 16'h2544 with wrap.
      res_in = 16'h2544; res_valid = 1'b1;
      push_a(4, 7'h66, 1, 0, 1);
      push_a(4, 7'h66, 0, 1, 1);
      push_a(4, 7'h6D, 0, 2, 1);
      push_a(4, 7'h5B, 0, 3, 1);
      push_a(4, 7'h66, 1, 0, 1);
      tick("load");
      res_valid = 1'b0;
      run(19, "seq");

      // Freeze mid-dwell at idx=1, then finish the remaining dwell.
      push_a(2, 7'h66, 0, 1, 1);
      run(2, "idx1");
      ena = 1'b0;
      push_a(10, 7'h66, 0, 1, 1);
      run(10, "freeze");
      ena = 1'b1;
      push_a(2, 7'h66, 0, 1, 1);
      push_a(2, 7'h6D, 0, 2, 1);
      run(4, "resume");

      // Preempt in cycle 2 of idx=2 with a fresh result.
      res_in = 16'h8888; res_valid = 1'b1;
      push_a(4, 7'h7F, 1, 0, 1);
      push_a(1, 7'h7F, 0, 1, 1);
      tick("preempt");
      res_valid = 1'b0;
      run(4, "preempt_dwell");

      // Error while showing: holds with no timeout.
      res_valid = 1'b1; err_in = 1'b1;
      push_a(101, 7'h79, 0, 0, 1);
      tick("err");
      res_valid = 1'b0; err_in = 1'b0;
      run(100, "err_hold");

      // res_valid ignored while disabled.
      ena = 1'b0; res_valid = 1'b1; res_in = 16'h1111;
      push_a(2, 7'h79, 0, 0, 1);
      run(2, "ena_low_valid");
      res_valid = 1'b0; ena = 1'b1;

      // Async reset mid-SHOW, then idle until the next result.
      res_in = 16'h2544; res_valid = 1'b1;
      push_a(3, 7'h66, 1, 0, 1);
      tick("load2");
      res_valid = 1'b0;
      run(2, "show2");
      #2 rst_n = 1'b0;
      #1 check("async_reset", {seg_a, dp_a, idx_a, busy_a}, ex(7'h00, 0, 0, 0));
      #3 rst_n = 1'b1;
      push_a(5, 7'h00, 0, 0, 0);
      run(5, "post_reset_idle");

      // Dwell-1 instance advances every cycle; dwell-4 instance checked alongside.
      res_in = 16'hFEDC; res_valid = 1'b1;
      push_a(4, 7'h39, 1, 0, 1);
      push_a(2, 7'h5E, 0, 1, 1);
      q_b.push_back(ex(7'h39, 1, 0, 1));
      q_b.push_back(ex(7'h5E, 0, 1, 1));
      q_b.push_back(ex(7'h79, 0, 2, 1));
      q_b.push_back(ex(7'h71, 0, 3, 1));
      q_b.push_back(ex(7'h39, 1, 0, 1));
      q_b.push_back(ex(7'h5E, 0, 1, 1));
      tick("fedc");
      res_valid = 1'b0;
      run(5, "fedc_seq");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mm_result_display.md
MM_RESULT_DISPLAY -- requirements
Module: mm_result_display

Interface
REQ-001 Parameter DWELL_CYCLES, default 50_000_000, number of clk cycles each result element is displayed (legal range 1 to 2^26).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ena  input  1  block enable; when low all state holds.
REQ-005 res_in  input  16  product matrix C from the multiplier stage: c11=[3:0], c12=[7:4], c21=[11:8], c22=[15:12], unsigned.
REQ-006 res_valid  input  1  single-cycle strobe; res_in/err_in are valid in the cycle it is high.
REQ-007 err_in  input  1  operand range error reported by the multiplier stage, qualified by res_valid.
REQ-008 seg  output  7  seven-segment pattern {g,f,e,d,c,b,a}, active-high, registered.
REQ-009 dp  output  1  decimal point, high while c11 is shown (sequence start marker), registered.
REQ-010 idx  output  2  index of the shown element: 0=c11, 1=c12, 2=c21, 3=c22, registered.
REQ-011 busy  output  1  high in SHOW or ERR state, registered.

Function
REQ-012 FSM states: IDLE (blank), SHOW (cycle through the four elements), ERR (error glyph).
REQ-013 IDLE: seg=7'h00, dp=0, idx=0, busy=0.
REQ-014 res_valid=1 and err_in=0 with ena=1 in any state: capture res_in into the hold register, set idx=0, clear the dwell counter, enter SHOW; seg shows the decoded c11 from the same clock edge.
REQ-015 res_valid=1 and err_in=1 with ena=1 in any state: enter ERR; seg=7'h79 ('E'), dp=0, idx=0, busy=1; the hold register keeps its previous contents.
REQ-016 SHOW: the dwell counter increments every enabled cycle; on reaching DWELL_CYCLES-1 it clears and idx advances by 1, wrapping 3->0; display repeats indefinitely.
REQ-017 Each element is displayed for exactly DWELL_CYCLES enabled cycles; with DWELL_CYCLES=1, idx advances every enabled cycle.
REQ-018 seg is the hex decode of the selected 4-bit element:
- 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
- 8=7F, 9=6F, A=77, B=7C, C=39, D=5E, E=79, F=71
REQ-019 A res_valid arriving mid-dwell or mid-sequence restarts at idx=0 with a fresh dwell count (a new result preempts the current one).
REQ-020 ERR persists until the next res_valid; there is no timeout.
REQ-021 res_valid with ena=0 is ignored.
REQ-022 ena=0: counter, FSM, hold register and outputs freeze; operation resumes from the same point when ena returns high.
REQ-023 Dwell counter width is ceil(log2(DWELL_CYCLES)), minimum 1 bit; it never exceeds DWELL_CYCLES-1.

Reset
REQ-024 rst_n low asynchronously forces:
- FSM=IDLE
- hold register=16'h0000
- dwell counter=0
- seg=7'h00, dp=0, idx=0, busy=0
REQ-025 Reset asserted mid-sequence abandons the sequence; after release the block stays in IDLE until the next res_valid.

Structure
REQ-026 Shared package mm_pkg holds the element width constant (4), the state enumeration, and the segment constants SEG_BLANK=7'h00 and SEG_ERR=7'h79.
REQ-027 The hex-to-segment decode is one combinational sub-module, seg7_hex_decode (4-bit in, 7-bit out), reusable by other display blocks.

Verification
REQ-028 DWELL_CYCLES=4, res_in=16'h2544, res_valid one cycle -> seg=66 for 4 cycles (dp=1, idx=0), then 66 for 4 (idx=1), then 6D for 4 (idx=2), then 5B for 4 (idx=3), then wraps to 66 with dp=1.
REQ-029 res_valid with err_in=1 while in SHOW -> the next edge gives seg=79, busy=1, idx=0; the state holds for 100 cycles.
REQ-030 16'h2544 loaded; in cycle 2 of idx=2, res_valid with 16'h8888 -> the next edge gives seg=7F, idx=0, dp=1, with a full 4-cycle dwell.
REQ-031 ena dropped for 10 cycles mid-dwell at idx=1 -> seg and idx are unchanged throughout; the remaining dwell cycles complete after ena returns.
REQ-032 rst_n asserted asynchronously mid-SHOW -> seg=00 and busy=0 without waiting for a clock edge; the block remains IDLE after release until res_valid.
REQ-033 DWELL_CYCLES=1, res_in=16'hFEDC -> the per-cycle seg sequence is 39, 5E, 79, 71, 39, and so on.
